// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//
// Oversampling UART receiver. A fractional accumulator makes a tick at
// BAUD*OVERSAMPLE. Each bit is decided by a 3-sample majority vote around
// the bit centre. The vote uses ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and
// OVERSAMPLE/2+1, counted from the tick where the start edge was seen.
// Frame layout: start, DATA_BITS data bits sent LSB first, an optional
// parity bit, then STOP_BITS stop bits.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits; parity_err is live.
//   undefined -> no parity bit is expected; parity_err is tied to 0.
//
// Ports
//   clk         in   system clock (CLK_FREQ Hz)
//   rst_n       in   asynchronous active-low reset
//   rxd         in   asynchronous serial line, idle high
//   data        out  last received word, right-aligned, upper bits 0;
//                    held until the next data_valid
//   data_valid  out  one-clk pulse when a frame completes (errors included)
//   frame_err   out  with data_valid: a checked stop bit was low
//   parity_err  out  with data_valid: parity check failed
//   idle        out  line high in IDLE for at least 2 bit times
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       idle
);

    // The accumulator never exceeds CLK_FREQ + increment, which is below
    // 2*CLK_FREQ, so two bits above log2(CLK_FREQ) are enough.
    localparam int              ACC_W   = $clog2(CLK_FREQ) + 2;
    localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_FREQ);
    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(BAUD * OVERSAMPLE);

    localparam int              CNT_W   = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_A   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] MID_B   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] MID_C   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(OVERSAMPLE - 1);

    localparam int               IDLE_TICKS = 2 * OVERSAMPLE;
    localparam int               IDLE_W     = $clog2(IDLE_TICKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_DONE  = IDLE_W'(IDLE_TICKS);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Tick generator
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic             tick_q, tick_d;

    // Synchroniser: sync_q[1] is the only copy of the line the FSM uses
    logic [1:0] sync_q, sync_d;
    logic       rx_s;

    // Receiver FSM and datapath
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;          // tick position inside a bit
    logic [2:0]        bit_cnt_q, bit_cnt_d;  // data / stop bit index
    logic              samp_a_q, samp_a_d;
    logic              samp_b_q, samp_b_d;
    logic              maj;
    logic [7:0]        shift_q, shift_d;
    logic              ferr_acc_q, ferr_acc_d; // a low stop bit seen so far
    logic              hold_q, hold_d;         // break hold-off
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

`ifdef UART_RX_PARITY_EN
    logic par_acc_q, par_acc_d;     // running XOR of received data bits
    logic perr_acc_q, perr_acc_d;   // parity verdict, reported at frame end
    logic parity_err_q, parity_err_d;
`endif

    // Registered outputs
    logic [7:0] data_q, data_d;
    logic       data_valid_q, data_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       idle_q, idle_d;

    assign rx_s = sync_q[1];

    // The third sample is taken directly from the line on the deciding tick.
    assign maj = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise always_comb would infer a latch.
        acc_d        = acc_q;
        tick_d       = 1'b0;
        sync_d       = {sync_q[0], rxd};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_a_d     = samp_a_q;
        samp_b_d     = samp_b_q;
        shift_d      = shift_q;
        ferr_acc_d   = ferr_acc_q;
        hold_d       = hold_q;
        idle_cnt_d   = idle_cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        idle_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_acc_d    = par_acc_q;
        perr_acc_d   = perr_acc_q;
        parity_err_d = 1'b0;
`endif

        // Fractional accumulator: add the tick rate each clock, wrap at the
        // clock rate and tick on every wrap. The rounding error never builds up.
        acc_sum = acc_q + ACC_INC;
        if (acc_sum >= ACC_MOD) begin
            acc_d  = acc_sum - ACC_MOD;
            tick_d = 1'b1;
        end else begin
            acc_d  = acc_sum;
        end

        // The hold-off ends as soon as the line is seen high in IDLE.
        if (state_q == ST_IDLE && rx_s) begin
            hold_d = 1'b0;
        end

        if (tick_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == MID_A) samp_a_d = rx_s;
            if (cnt_q == MID_B) samp_b_d = rx_s;

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    // The detecting tick counts as tick 0 of the start bit.
                    if (!rx_s && !hold_q) begin
                        state_d = ST_START;
                        cnt_d   = CNT_W'(1);
                    end
                end

                ST_START: begin
                    if (cnt_q == MID_C && maj) begin
                        state_d = ST_IDLE;     // false start, no output
                        cnt_d   = '0;
                    end else if (cnt_q == BIT_END) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_acc_d  = 1'b0;
                        perr_acc_d = 1'b0;
`endif
                    end
                end

                ST_DATA: begin
                    if (cnt_q == MID_C) begin
                        shift_d[bit_cnt_q] = maj;
`ifdef UART_RX_PARITY_EN
                        par_acc_d = par_acc_q ^ maj;
`endif
                    end
                    if (cnt_q == BIT_END) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = ST_PARITY;
`else
                            state_d   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == MID_C) begin
                        perr_acc_d = ((par_acc_q ^ maj) != PARITY_ODD);
                    end
                    if (cnt_q == BIT_END) begin
                        state_d = ST_STOP;
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt_q == MID_C) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            // Frame ends on the last stop-bit decision. The
                            // rest of that stop bit is spent in IDLE, so a
                            // back-to-back start edge is caught.
                            state_d      = ST_IDLE;
                            cnt_d        = '0;
                            data_valid_d = 1'b1;
                            data_d       = shift_q;
                            frame_err_d  = ferr_acc_q | ~maj;
                            hold_d       = ferr_acc_q | ~maj;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = perr_acc_q;
`endif
                        end else begin
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            ferr_acc_d = ferr_acc_q | ~maj;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Idle qualification restarts whenever the line drops or the FSM
        // leaves IDLE, so idle falls in the same cycle the FSM moves on.
        if (state_d != ST_IDLE || !rx_s) begin
            idle_cnt_d = '0;
        end else if (tick_q && idle_cnt_q != IDLE_DONE) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        idle_d = (idle_cnt_d == IDLE_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            tick_q       <= 1'b0;
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            samp_a_q     <= 1'b0;
            samp_b_q     <= 1'b0;
            shift_q      <= '0;
            ferr_acc_q   <= 1'b0;
            hold_q       <= 1'b0;
            idle_cnt_q   <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            idle_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= 1'b0;
            perr_acc_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            acc_q        <= acc_d;
            tick_q       <= tick_d;
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_a_q     <= samp_a_d;
            samp_b_q     <= samp_b_d;
            shift_q      <= shift_d;
            ferr_acc_q   <= ferr_acc_d;
            hold_q       <= hold_d;
            idle_cnt_q   <= idle_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            idle_q       <= idle_d;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= par_acc_d;
            perr_acc_q   <= perr_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign idle       = idle_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
//
// Bench for uart_rx_param. Two receivers run at 1 tick per clk (16 clk per
// bit): dut8 is 8N1 and dut5 is 5 data bits with 2 stop bits. Each frame
// sent pushes its expected word and error flags into a per-receiver queue.
// A monitor pops and compares on every data_valid. The parity bit is sent
// only when UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1843200;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 16;
    localparam bit PODD     = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd8  = 1'b1;
    logic       rxd5  = 1'b1;
    logic [7:0] data8, data5;
    logic       dv8, fe8, pe8, idle8;
    logic       dv5, fe5, pe5, idle5;

    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q5[$];
    exp_t e8, e5;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd8), .data(data8),
        .data_valid(dv8), .frame_err(fe8), .parity_err(pe8), .idle(idle8)
    );

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(PODD)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd5), .data(data5),
        .data_valid(dv5), .frame_err(fe5), .parity_err(pe5), .idle(idle5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity bit value a correct transmitter would send.
    function automatic logic pgood(input logic [7:0] d);
        return (^d) ^ PODD;
    endfunction

    // Expected parity verdict for a word and the parity bit actually sent.
    function automatic logic exp_perr(input logic [7:0] d, input logic pbit);
`ifdef UART_RX_PARITY_EN
        return ((^d) ^ pbit) != PODD;
`else
        return 1'b0 & d[0] & pbit;
`endif
    endfunction

    // Hold one line at a level for one bit time. Changes happen on negedges.
    task automatic drive_bit(input bit to5, input logic v);
        if (to5) rxd5 = v;
        else     rxd8 = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Send one frame. stops[0] is the first stop bit. gap is the number of
    // idle-high bit times driven after the frame.
    task automatic send(input bit to5, input logic [7:0] d, input logic pbit,
                        input logic [1:0] stops, input int gap);
        int         nbits;
        logic [7:0] dm;
        exp_t       e;
        nbits  = to5 ? 5 : 8;
        dm     = d & 8'((1 << nbits) - 1);
        e.data = dm;
        e.ferr = (stops[0] == 1'b0) || (to5 && stops[1] == 1'b0);
        e.perr = exp_perr(dm, pbit);
        if (to5) q5.push_back(e);
        else     q8.push_back(e);
        drive_bit(to5, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(to5, dm[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(to5, pbit);
`endif
        drive_bit(to5, stops[0]);
        if (to5) drive_bit(to5, stops[1]);
        for (int i = 0; i < gap; i++) drive_bit(to5, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (q8.size() == 0 && q5.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(q8.size() + q5.size()), 0);
    endtask

    // Monitors: compare each valid word with the oldest expectation. Outside
    // a valid cycle the error flags must stay low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv8) begin
                if (q8.size() == 0) begin
                    check("dut8_unexpected_valid", 32'(dv8), 0);
                end else begin
                    e8 = q8.pop_front();
                    check("dut8_data", 32'(data8), 32'(e8.data));
                    check("dut8_frame_err", 32'(fe8), 32'(e8.ferr));
                    check("dut8_parity_err", 32'(pe8), 32'(e8.perr));
                end
            end else begin
                check("dut8_flags_outside_valid", 32'({fe8, pe8}), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv5) begin
                if (q5.size() == 0) begin
                    check("dut5_unexpected_valid", 32'(dv5), 0);
                end else begin
                    e5 = q5.pop_front();
                    check("dut5_data", 32'(data5), 32'(e5.data));
                    check("dut5_frame_err", 32'(fe5), 32'(e5.ferr));
                    check("dut5_parity_err", 32'(pe5), 32'(e5.perr));
                end
            end else begin
                check("dut5_flags_outside_valid", 32'({fe5, pe5}), 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       pb;
        logic       stop_ok;
        logic [1:0] stops;
        int         gap;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_dut8", 32'({data8, dv8, fe8, pe8, idle8}), 0);
        check("reset_outputs_dut5", 32'({data5, dv5, fe5, pe5, idle5}), 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("idle_after_reset_dut8", 32'(idle8), 1);
        check("idle_after_reset_dut5", 32'(idle5), 1);

        // Basic 8N1 frame
        send(1'b0, 8'hA5, pgood(8'hA5), 2'b11, 2);
        wait_drain();

`ifdef UART_RX_PARITY_EN
        // Parity bit wrong for 0x07 under even parity, then correct
        send(1'b0, 8'h07, 1'b0, 2'b11, 1);
        send(1'b0, 8'h07, 1'b1, 2'b11, 1);
        wait_drain();
`endif

        // Stop bit low, then the line held low as a 40-bit break
        send(1'b0, 8'h3C, pgood(8'h3C), 2'b10, 0);
        repeat (20) drive_bit(1'b0, 1'b0);
        check("idle_low_during_break", 32'(idle8), 0);
        repeat (20) drive_bit(1'b0, 1'b0);
        repeat (3) drive_bit(1'b0, 1'b1);
        wait_drain();
        send(1'b0, 8'h81, pgood(8'h81), 2'b11, 2);
        wait_drain();

        // A 4-clk glitch on an idle line is a false start
        repeat (40) @(negedge clk);
        check("idle_before_glitch", 32'(idle8), 1);
        rxd8 = 1'b0;
        repeat (4) @(negedge clk);
        rxd8 = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_drops_on_glitch", 32'(idle8), 0);
        repeat (60) @(negedge clk);
        check("idle_requalified_after_glitch", 32'(idle8), 1);

        // 5 data bits with 2 stop bits: clean, then second stop bit low
        send(1'b1, 8'h1F, pgood(8'h1F), 2'b11, 1);
        send(1'b1, 8'h1F, pgood(8'h1F), 2'b01, 1);
        wait_drain();

        // Randomised 8N1 traffic, back-to-back frames included
        for (int i = 0; i < 24; i++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            pb      = ($urandom_range(0, 3) == 0) ? ~pgood(d) : pgood(d);
            gap     = stop_ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send(1'b0, d, pb, {1'b1, stop_ok}, gap);
        end
        wait_drain();

        // Randomised 5-bit / 2-stop traffic
        for (int i = 0; i < 10; i++) begin
            d     = 8'($urandom_range(0, 31));
            stops = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
            pb    = ($urandom_range(0, 3) == 0) ? ~pgood(d) : pgood(d);
            gap   = stops[1] ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send(1'b1, d, pb, stops, gap);
        end
        wait_drain();

        // Reset pulsed during data bit 4 abandons the frame
        d = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
        rxd8 = d[4];
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs_dut8", 32'({data8, dv8, fe8, pe8, idle8}), 0);
        check("midframe_reset_outputs_dut5", 32'({data5, dv5, fe5, pe5, idle5}), 0);
        rxd8 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        send(1'b0, 8'h55, pgood(8'h55), 2'b11, 2);
        wait_drain();
        repeat (40) @(negedge clk);
        check("idle_at_end_dut8", 32'(idle8), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16: ticks per bit; power of 2, minimum 8.
REQ-004 Parameter DATA_BITS, default 8: data bits per frame, 5 to 8.
REQ-005 Parameter STOP_BITS, default 1: stop bits checked, 1 or 2.
REQ-006 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd.
REQ-007 Port clk, input, 1 bit: the block's only clock.
REQ-008 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-010 Port data, output, 8 bits: received word, LSB-first assembled, right-aligned; unused upper bits are 0.
REQ-011 Port data_valid, output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 Port frame_err, output, 1 bit: qualifies data_valid; a checked stop bit was sampled low.
REQ-013 Port parity_err, output, 1 bit: qualifies data_valid; the parity check failed.
REQ-014 Port idle, output, 1 bit: line idle for at least 2 bit times.

Function
REQ-015 The tick generator SHALL be a fractional accumulator producing one-cycle ticks at BAUD*OVERSAMPLE with at most ±2% error per frame; it runs continuously.
REQ-016 rxd SHALL pass through a 2-flop synchroniser before use.
REQ-017 Each bit value SHALL be the majority of 3 samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE→START on a synchronised low level at a tick.
REQ-019 In START, a majority value of 1 SHALL return the FSM to IDLE with no output (false start); otherwise it SHALL go to DATA.
REQ-020 DATA SHALL capture DATA_BITS bits LSB-first, then go to PARITY when parity is enabled, else to STOP.
REQ-021 PARITY SHALL sample one bit; the error condition is (XOR of the data bits XOR the parity bit) != PARITY_ODD.
REQ-022 STOP SHALL sample STOP_BITS bits; if any is low, frame_err is set.
REQ-023 data_valid SHALL pulse for exactly one clk, one cycle after the last stop-bit majority decision, whether or not an error occurred; frame_err and parity_err are valid only in that cycle and are 0 otherwise.
REQ-024 data SHALL hold its value until the next data_valid.
REQ-025 After STOP the FSM SHALL return to IDLE. A low line at that point starts a new frame; there is no back-to-back gap requirement.
REQ-026 A low line that persists through STOP SHALL yield frame_err, and the FSM SHALL NOT restart until the line has been seen high at least once (break hold-off).
REQ-027 idle SHALL assert after 2*OVERSAMPLE consecutive ticks in IDLE with the line high, and SHALL deassert on leaving IDLE.

Reset
REQ-028 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, the synchroniser SHALL be 1, and the accumulator and counters SHALL be 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no data_valid; reception resumes at the next start edge after release.

Configuration
REQ-030 When UART_RX_PARITY_EN is defined, the PARITY state and parity_err logic SHALL be compiled in and a parity bit is expected after the data bits.
REQ-031 When UART_RX_PARITY_EN is undefined, no parity bit is expected and parity_err SHALL be tied to 0.

Verification
All scenarios use CLK_FREQ=1843200, BAUD=115200, OVERSAMPLE=16, i.e. 1 tick per clk and 16 clk per bit.
REQ-032 8N1 frame 0xA5 -> data=0xA5, one data_valid pulse, frame_err=0, parity_err=0.
REQ-033 Frame 0x3C with the stop bit driven low -> data=0x3C, data_valid=1, frame_err=1; the line then held low for 40 bits gives no further data_valid until it returns high.
REQ-034 UART_RX_PARITY_EN defined, even parity, data 0x07 with parity bit 0 -> parity_err=1; the same frame with parity bit 1 -> parity_err=0.
REQ-035 A 4-clk low glitch on an idle line -> no data_valid, FSM back in IDLE, idle stays 1 once re-qualified.
REQ-036 rst_n pulsed low during data bit 4 of a frame -> all outputs 0 at once, no data_valid; the following frame 0x55 is received correctly.
REQ-037 DATA_BITS=5, STOP_BITS=2, frame 0x1F -> data=0x1F; the second stop bit driven low -> frame_err=1.
